rx_tlp_store_fwd: RTL and testbench
===================================

# rx_tlp_store_fwd

Store-and-forward receive TLP buffer on the RX path's LPIF output, between the LPIF RX gasket (pl_* outputs) and the Data Link Layer receive logic. Accepts a DW-aligned beat stream with start/end/EDB markers and buffers each TLP until its end marker. Releases only complete, non-nullified packets to the DLL through a valid/ready stream. Nullified (EDB), truncated, overflowing and malformed packets are rolled back and never seen downstream.

## Interface
- DATA_W, 32, beat width in bits (one DW per beat)
- DEPTH, 64, buffer entries; power of two, ≥ 8
- MIN_DW, 3, minimum legal TLP length in beats; shorter packets are malformed
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- pl_valid  in  1  input beat valid
- pl_data  in  DATA_W  input beat
- pl_tlpstart  in  1  beat is first DW of a TLP
- pl_tlpend  in  1  beat is last DW of a TLP
- pl_tlpedb  in  1  packet ends nullified (EDB)
- tlp_valid  out  1  output beat available
- tlp_data  out  DATA_W  output beat
- tlp_sop  out  1  output beat is first of packet
- tlp_eop  out  1  output beat is last of packet
- tlp_ready  in  1  DLL accepts beat
- free_entries  out  log2(DEPTH)+1  DEPTH minus occupied (committed + uncommitted) entries
- cnt_nullified, cnt_dropped, cnt_malformed  out  16 each  event counters

## Operation
- Storage: DEPTH × (DATA_W+2) array {sop, eop, data}. Pointers wr_ptr, commit_ptr, rd_ptr, each log2(DEPTH)+1 bits (wrap bit for full/empty). Also pkt_len counter and drop flag.
- Write FSM states: IDLE, IN_PKT, DROP.
- IDLE: pl_valid & pl_tlpstart -> write beat with sop=1, pkt_len=1, go IN_PKT. Beats without start are ignored.
- If start beat also has end: len 1 < MIN_DW -> malformed, rollback, stay IDLE (unless MIN_DW=1, then commit).
- IN_PKT: each pl_valid beat written at wr_ptr, wr_ptr++, pkt_len++ (saturating).
- pl_tlpend & !pl_tlpedb: write beat with eop=1; if pkt_len+1 ≥ MIN_DW, commit_ptr <= wr_ptr+1; else malformed rollback (wr_ptr <= commit_ptr). Go IDLE.
- pl_tlpedb (with or without pl_tlpend): beat not written; wr_ptr <= commit_ptr; cnt_nullified++; go IDLE. EDB beats in IDLE/DROP are ignored.
- pl_tlpstart while IN_PKT: partial packet rolled back, cnt_malformed++, the new start beat begins a new packet (written at the old commit_ptr).
- Overflow: valid beat in IN_PKT with buffer full -> rollback, cnt_dropped++, go DROP. DROP discards beats until end/EDB (-> IDLE) or a new start (-> treated as IDLE start same cycle).
- Read side: tlp_valid = (rd_ptr != commit_ptr); tlp_data/sop/eop = array[rd_ptr] (asynchronous read). tlp_valid & tlp_ready -> rd_ptr++. Uncommitted entries are never readable.
- Full = (wr_ptr - rd_ptr) == DEPTH, from registered pointers.
- Counters saturate at 16'hFFFF.

## Timing
- Reset (reset=0, async): all pointers 0, FSM IDLE, pkt_len 0, counters 0; tlp_valid=0, tlp_sop=0, tlp_eop=0, tlp_data=0 (array contents don't-care), free_entries=DEPTH. Buffered packets are lost; a partial packet arriving after release is ignored until next start.
- Latency: end beat registered at edge N; tlp_valid rises after edge N (earliest one cycle after end beat presented). First beat of a packet appears no earlier than that.
- Throughput: one write and one read per cycle concurrently.
- A read in the same cycle as a full-buffer write does not prevent the overflow; space freed by reads is seen next cycle.
- free_entries updates the cycle after the write/read/rollback edge.
- Write side has no backpressure; the DLL sizes its credit advertisement from free_entries.

## Configuration
- RX_TLP_STATS_EN: defined -> three 16-bit saturating counters implemented as above. Undefined -> counter registers not built, cnt_* tied to 0; packet handling identical.

## Test plan
- 4-beat TLP (start beat 1, end beat 4, data 0x11..0x44), tlp_ready=1 -> 4 beats out, sop on 0x11, eop on 0x44, tlp_valid rises the cycle after end.
- 5-beat TLP ending with pl_tlpend=1, pl_tlpedb=1 -> nothing output, cnt_nullified=1, free_entries returns to 64.
- tlp_ready=0, stream 17 four-beat TLPs into DEPTH=64 -> first 16 committed, 17th dropped, cnt_dropped=1; releasing ready drains exactly 64 beats.
- 2-beat packet (start+end) with MIN_DW=3 -> discarded, cnt_malformed=1; following 3-beat packet delivered intact.
- Start, 2 beats, then new start with 3-beat packet -> only the second packet delivered, cnt_malformed=1.
- Reset asserted mid-packet with 2 committed packets buffered -> tlp_valid=0, free_entries=64 immediately; post-reset beats before a start are ignored.

Source files
------------

// File: rtl/rx_tlp_store_fwd_if.sv
// rtl/rx_tlp_store_fwd_if.sv - LPIF RX beat stream in, DLL TLP stream out
interface rx_tlp_store_fwd_if #(
    parameter int DATA_W = 32
);
    logic              pl_valid;
    logic [DATA_W-1:0] pl_data;
    logic              pl_tlpstart;
    logic              pl_tlpend;
    logic              pl_tlpedb;
    logic              tlp_valid;
    logic [DATA_W-1:0] tlp_data;
    logic              tlp_sop;
    logic              tlp_eop;
    logic              tlp_ready;

    modport master (
        output pl_valid, pl_data, pl_tlpstart, pl_tlpend, pl_tlpedb, tlp_ready,
        input  tlp_valid, tlp_data, tlp_sop, tlp_eop
    );

    modport slave (
        input  pl_valid, pl_data, pl_tlpstart, pl_tlpend, pl_tlpedb, tlp_ready,
        output tlp_valid, tlp_data, tlp_sop, tlp_eop
    );
endinterface

// File: rtl/rx_tlp_store_fwd.sv
// rtl/rx_tlp_store_fwd.sv - store-and-forward RX TLP buffer; RX_TLP_STATS_EN builds event counters
module rx_tlp_store_fwd #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int MIN_DW = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    rx_tlp_store_fwd_if.slave      bus,
    output logic [$clog2(DEPTH):0] free_entries,
    output logic [15:0]            cnt_nullified,
    output logic [15:0]            cnt_dropped,
    output logic [15:0]            cnt_malformed
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE     = PW'(1);

    typedef enum logic [1:0] {IDLE, IN_PKT, DROP} wrState_t;

    logic [DATA_W+1:0] mem [DEPTH];

    wrState_t      state, stateNext;
    logic [PW-1:0] wrPtr, commitPtr, rdPtr;
    logic [PW-1:0] wrPtrNext, commitPtrNext;
    logic [15:0]   pktLen, pktLenNext, lenInc;
    logic          full, commitFull, lenOk;
    logic          wrEn, wrSop, wrEop;
    logic [AW-1:0] wrAddr;
    logic          nullInc, dropInc;
    logic [1:0]    malInc;
    logic          tlpValid, rdEn;
    logic [DATA_W+1:0] rdWord;

    assign full       = (wrPtr - rdPtr) == DEPTH_P;
    assign commitFull = (commitPtr - rdPtr) == DEPTH_P;
    assign lenInc     = (pktLen == 16'hFFFF) ? pktLen : pktLen + 16'd1;
    assign lenOk      = {16'd0, lenInc} >= 32'(MIN_DW);

    assign free_entries = DEPTH_P - (wrPtr - rdPtr);

    // Only committed entries are visible; outputs are forced low when nothing is readable.
    assign tlpValid      = (rdPtr != commitPtr);
    assign rdEn          = tlpValid & bus.tlp_ready;
    assign rdWord        = mem[rdPtr[AW-1:0]];
    assign bus.tlp_valid = tlpValid;
    assign bus.tlp_sop   = tlpValid & rdWord[DATA_W+1];
    assign bus.tlp_eop   = tlpValid & rdWord[DATA_W];
    assign bus.tlp_data  = tlpValid ? rdWord[DATA_W-1:0] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wrPtr     <= '0;
            commitPtr <= '0;
            rdPtr     <= '0;
            pktLen    <= '0;
        end else begin
            state     <= stateNext;
            wrPtr     <= wrPtrNext;
            commitPtr <= commitPtrNext;
            pktLen    <= pktLenNext;
            if (rdEn) rdPtr <= rdPtr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) mem[wrAddr] <= {wrSop, wrEop, bus.pl_data};
    end

    always_comb begin
        stateNext     = state;
        wrPtrNext     = wrPtr;
        commitPtrNext = commitPtr;
        pktLenNext    = pktLen;
        wrEn          = 1'b0;
        wrAddr        = wrPtr[AW-1:0];
        wrSop         = 1'b0;
        wrEop         = 1'b0;
        nullInc       = 1'b0;
        dropInc       = 1'b0;
        malInc        = 2'd0;
        if (bus.pl_valid) begin
            if (bus.pl_tlpstart) begin
                // Any start re-bases the packet at commitPtr, discarding a partial one.
                if (state == IN_PKT) malInc = 2'd1;
                wrPtrNext  = commitPtr;
                pktLenNext = '0;
                stateNext  = IDLE;
                if (bus.pl_tlpedb) begin
                    nullInc = 1'b1;
                end else if (commitFull) begin
                    dropInc   = 1'b1;
                    stateNext = bus.pl_tlpend ? IDLE : DROP;
                end else begin
                    wrEn   = 1'b1;
                    wrAddr = commitPtr[AW-1:0];
                    wrSop  = 1'b1;
                    wrEop  = bus.pl_tlpend;
                    if (!bus.pl_tlpend) begin
                        wrPtrNext  = commitPtr + ONE;
                        pktLenNext = 16'd1;
                        stateNext  = IN_PKT;
                    end else if (MIN_DW <= 1) begin
                        wrPtrNext     = commitPtr + ONE;
                        commitPtrNext = commitPtr + ONE;
                    end else begin
                        malInc = malInc + 2'd1;
                    end
                end
            end else if (state == IN_PKT) begin
                if (bus.pl_tlpedb) begin
                    wrPtrNext  = commitPtr;
                    pktLenNext = '0;
                    nullInc    = 1'b1;
                    stateNext  = IDLE;
                end else if (full) begin
                    wrPtrNext  = commitPtr;
                    pktLenNext = '0;
                    dropInc    = 1'b1;
                    stateNext  = bus.pl_tlpend ? IDLE : DROP;
                end else begin
                    wrEn       = 1'b1;
                    wrEop      = bus.pl_tlpend;
                    wrPtrNext  = wrPtr + ONE;
                    pktLenNext = lenInc;
                    if (bus.pl_tlpend) begin
                        pktLenNext = '0;
                        stateNext  = IDLE;
                        if (lenOk) begin
                            commitPtrNext = wrPtr + ONE;
                        end else begin
                            wrPtrNext = commitPtr;
                            malInc    = 2'd1;
                        end
                    end
                end
            end else if (state == DROP) begin
                if (bus.pl_tlpend || bus.pl_tlpedb) stateNext = IDLE;
            end
        end
    end

`ifdef RX_TLP_STATS_EN
    function automatic logic [15:0] satAdd(input logic [15:0] c, input logic [1:0] n);
        logic [16:0] s;
        s = {1'b0, c} + {15'd0, n};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_nullified <= '0;
            cnt_dropped   <= '0;
            cnt_malformed <= '0;
        end else begin
            cnt_nullified <= satAdd(cnt_nullified, {1'b0, nullInc});
            cnt_dropped   <= satAdd(cnt_dropped, {1'b0, dropInc});
            cnt_malformed <= satAdd(cnt_malformed, malInc);
        end
    end
`else
    logic unusedStats;
    assign unusedStats   = ^{nullInc, dropInc, malInc};
    assign cnt_nullified = '0;
    assign cnt_dropped   = '0;
    assign cnt_malformed = '0;
`endif
endmodule

// File: tb/tb_rx_tlp_store_fwd.sv
// tb/tb_rx_tlp_store_fwd.sv - randomized bench for rx_tlp_store_fwd against a queue-based packet model
module tb_rx_tlp_store_fwd;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int MIN_DW = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rx_tlp_store_fwd_if #(.DATA_W(DATA_W)) bus ();
    logic [6:0]  free_entries;
    logic [15:0] cnt_nullified, cnt_dropped, cnt_malformed;

    rx_tlp_store_fwd #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MIN_DW(MIN_DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .free_entries  (free_entries),
        .cnt_nullified (cnt_nullified),
        .cnt_dropped   (cnt_dropped),
        .cnt_malformed (cnt_malformed)
    );

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [31:0] data;
    } beat_t;

    beat_t expQ[$];
    beat_t partQ[$];
    bit    inPkt, dropping, rdy;
    int    nNull, nDrop, nMal;
    int    numChecks, numErrors, drained;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] expCnt(input int n);
`ifdef RX_TLP_STATS_EN
        return (n > 65535) ? 32'd65535 : 32'(n);
`else
        return (n < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic modelClear();
        expQ.delete();
        partQ.delete();
        inPkt = 0; dropping = 0;
        nNull = 0; nDrop = 0; nMal = 0;
    endtask

    // Packet-level rules: committed packets queue up whole, partial ones vanish on abort.
    task automatic modelBeat(input bit v, input logic [31:0] d, input bit s, input bit e, input bit x);
        if (!v) return;
        if (s) begin
            if (inPkt) begin nMal++; partQ.delete(); end
            inPkt = 0; dropping = 0;
            if (x) nNull++;
            else if (expQ.size() == DEPTH) begin nDrop++; dropping = !e; end
            else if (e) begin
                if (MIN_DW <= 1) expQ.push_back({1'b1, 1'b1, d});
                else nMal++;
            end else begin
                partQ.push_back({1'b1, 1'b0, d});
                inPkt = 1;
            end
        end else if (inPkt) begin
            if (x) begin
                partQ.delete(); nNull++; inPkt = 0;
            end else if (expQ.size() + partQ.size() == DEPTH) begin
                partQ.delete(); nDrop++; inPkt = 0; dropping = !e;
            end else begin
                partQ.push_back({1'b0, e, d});
                if (e) begin
                    if (partQ.size() >= MIN_DW) foreach (partQ[i]) expQ.push_back(partQ[i]);
                    else nMal++;
                    partQ.delete();
                    inPkt = 0;
                end
            end
        end else if (dropping) begin
            if (e || x) dropping = 0;
        end
    endtask

    task automatic checkOutputs();
        checkVal("tlp_valid", bus.tlp_valid, expQ.size() > 0);
        if (expQ.size() > 0) begin
            checkVal("tlp_data", bus.tlp_data, expQ[0].data);
            checkVal("tlp_sop", bus.tlp_sop, expQ[0].sop);
            checkVal("tlp_eop", bus.tlp_eop, expQ[0].eop);
        end
        checkVal("free_entries", free_entries, DEPTH - expQ.size() - partQ.size());
        checkVal("cnt_nullified", cnt_nullified, expCnt(nNull));
        checkVal("cnt_dropped", cnt_dropped, expCnt(nDrop));
        checkVal("cnt_malformed", cnt_malformed, expCnt(nMal));
    endtask

    // One clock: drive at negedge, check #1 later, update the model at the edge.
    task automatic cycle(input bit v, input logic [31:0] d, input bit s, input bit e, input bit x);
        bit hs;
        bus.pl_valid    = v;
        bus.pl_data     = d;
        bus.pl_tlpstart = s;
        bus.pl_tlpend   = e;
        bus.pl_tlpedb   = x;
        bus.tlp_ready   = rdy;
        #1;
        checkOutputs();
        hs = rdy && (expQ.size() > 0);
        if (rdy && bus.tlp_valid) drained++;
        modelBeat(v, d, s, e, x);
        if (hs) void'(expQ.pop_front());
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 32'h0, 0, 0, 0);
    endtask

    task automatic sendPkt(input int n, input logic [31:0] base, input logic [31:0] step, input bit edbEnd);
        for (int i = 0; i < n; i++)
            cycle(1, base + step * i, i == 0, i == n - 1, edbEnd && (i == n - 1));
    endtask

    task automatic resetCheck(input string tag);
        checkVal({tag, "_valid"}, bus.tlp_valid, 1'b0);
        checkVal({tag, "_sop"}, bus.tlp_sop, 1'b0);
        checkVal({tag, "_eop"}, bus.tlp_eop, 1'b0);
        checkVal({tag, "_data"}, bus.tlp_data, 32'h0);
        checkVal({tag, "_free"}, free_entries, DEPTH);
        checkVal({tag, "_cnt"}, {cnt_nullified, cnt_dropped | cnt_malformed}, 32'h0);
    endtask

    task automatic midReset();
        #2 reset = 1'b0;
        #1;
        modelClear();
        resetCheck("midrst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bus.pl_valid = 0; bus.pl_data = '0; bus.pl_tlpstart = 0;
        bus.pl_tlpend = 0; bus.pl_tlpedb = 0; bus.tlp_ready = 0;
        rdy = 0; numChecks = 0; numErrors = 0; drained = 0;
        modelClear();
        repeat (2) @(negedge clk);
        resetCheck("rst");
        reset = 1'b1;
        @(negedge clk);

        rdy = 1;
        sendPkt(4, 32'h11, 32'h11, 0);
        idle(6);

        sendPkt(5, 32'hA0, 1, 1);
        idle(3);

        rdy = 0;
        for (int p = 0; p < 17; p++) sendPkt(4, 32'h1000 + 32'(p) * 16, 1, 0);
        checkVal("full_free", free_entries, 0);
        drained = 0;
        rdy = 1;
        idle(70);
        checkVal("drain_beats", drained, 64);

        sendPkt(2, 32'hB0, 1, 0);
        sendPkt(3, 32'hC0, 1, 0);
        idle(5);

        cycle(1, 32'hD0, 1, 0, 0);
        cycle(1, 32'hD1, 0, 0, 0);
        sendPkt(3, 32'hE0, 1, 0);
        idle(5);

        rdy = 0;
        sendPkt(4, 32'h200, 1, 0);
        sendPkt(4, 32'h300, 1, 0);
        cycle(1, 32'h400, 1, 0, 0);
        cycle(1, 32'h401, 0, 0, 0);
        midReset();
        rdy = 1;
        cycle(1, 32'h500, 0, 0, 0);
        cycle(1, 32'h501, 0, 1, 0);
        sendPkt(3, 32'h600, 1, 0);
        idle(5);

        for (int c = 0; c < 4000; c++) begin
            if (c % 400 == 0) rdy = 0;
            if (c == 2000) midReset();
            rdy = ((c / 400) % 2 == 0) ? ($urandom_range(99) < 80) : ($urandom_range(99) < 15);
            cycle($urandom_range(9) < 7, $urandom, $urandom_range(99) < 18,
                  $urandom_range(99) < 22, $urandom_range(99) < 4);
        end
        rdy = 1;
        idle(80);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end
endmodule
